tick_event_scheduler: RTL and testbench
=======================================

Name: tick_event_scheduler

Overview:
Multi-channel timer scheduler driven by the single-cycle tick pulse from the system clock divider.
- Each channel counts a programmable number of ticks and raises an event, either once (one-shot) or repeatedly (periodic).
- Pending events from all channels share one event output port.
- Round-robin arbitration selects among pending channels; the output uses a valid/ready handshake.

Parameters:
- NUM_CH, 4, number of timer channels (2..16).
- CNT_WIDTH, 16, width of period and countdown counters.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- tick_in  input  1  single-cycle tick enable from the clock divider.
- cfg_we  input  1  configuration write strobe.
- cfg_ch  input  $clog2(NUM_CH)  channel addressed by the write.
- cfg_period  input  CNT_WIDTH  period in ticks.
- cfg_mode  input  1  0 = one-shot, 1 = periodic.
- cfg_enable  input  1  1 = start/restart channel, 0 = stop channel.
- evt_valid  output  1  an event is presented.
- evt_ch  output  $clog2(NUM_CH)  channel of the presented event.
- evt_ready  input  1  consumer accepts the event.
- busy  output  NUM_CH  per-channel RUN indicator.
- overrun  output  NUM_CH  sticky per-channel overrun flag (optional feature).
- ovr_clr  input  NUM_CH  per-channel overrun clear (optional feature).

Behaviour:
- Reset (reset_n low, async):
  - all channels IDLE; counters, pend, overrun = 0.
  - evt_valid = 0, evt_ch = 0, busy = 0, round-robin pointer = 0.
- Per-channel state: IDLE, RUN. busy[i] = (state == RUN).
- Config write (cfg_we = 1):
  - cfg_enable = 1 and cfg_period != 0: load cnt = cfg_period, latch mode, go to RUN. Applies from RUN too (restart).
  - cfg_enable = 1 and cfg_period == 0: write ignored; channel state unchanged.
  - cfg_enable = 0: channel goes to IDLE. An already-set pend is NOT cleared and is still delivered.
  - cfg_ch >= NUM_CH: write ignored.
- Counting: on each cycle with tick_in = 1, every RUN channel not being written this cycle:
  - cnt > 1: cnt decrements.
  - cnt == 1: channel expires. Periodic: reload cnt = period, stay in RUN. One-shot: go to IDLE.
  - Expiry sets pend[i] at the next clock edge.
- Simultaneous config write and tick on the same channel: the config write wins; that tick is ignored for that channel.
- Expiry while pend[i] is already set: overrun[i] sets. Events are not queued; pend stays 1.
- Handshake clear and a new expiry on the same channel in the same cycle: pend stays 1; no overrun.
- Arbitration:
  - When no event is locked and any pend is set, select the first pending channel at or above the pointer, wrapping modulo NUM_CH.
  - Lock the selection; evt_valid = 1, evt_ch = selected channel.
- Event output stability: evt_valid and evt_ch are registered and held stable until evt_valid & evt_ready.
- Handshake completion:
  - clears pend[evt_ch] (subject to the simultaneous-expiry rule above).
  - sets pointer = evt_ch + 1, wrapping.
  - evt_valid drops for one cycle before the next grant. Maximum throughput is one event per 2 cycles.
- Latency: expiry at edge t sets pend at t; with no contention, evt_valid is high after edge t+1.
- Period P: with tick_in every K cycles, a periodic channel expires every P ticks exactly (reload occurs on the expiring tick).
- Counter arithmetic is unsigned; no wrap-around below 1 is possible.

Optional Feature:
- Macro: TICK_SCHED_OVERRUN_EN.
- Defined:
  - overrun and ovr_clr ports exist; overrun[i] is sticky per the rules above.
  - ovr_clr[i] = 1 clears overrun[i]. If set and clear occur in the same cycle, set wins.
- Undefined:
  - overrun and ovr_clr ports are absent.
  - Overrun expiries are silently dropped; all other behaviour is identical.

Test Plan:
- Reset mid-operation:
  - Setup: ch1 RUN with cnt = 3, pend[0] = 1, evt_valid = 1.
  - Action: assert reset_n = 0 asynchronously.
  - Required: all outputs 0 immediately; no event after release until a new config write.
- One-shot channel 2:
  - Setup: write period = 3, mode = 0, enable; tick_in pulses every 5 cycles; evt_ready = 1.
  - Required: exactly one event with evt_ch = 2, evt_valid high the cycle after the edge sampling the 3rd tick; busy[2] falls at that same edge.
- Periodic channel 0 with back-pressure:
  - Setup: period = 2, mode = 1; evt_ready = 0 for 6 ticks.
  - Required: evt_ch = 0 held stable; overrun[0] = 1 after the 4th tick.
  - Then: ovr_clr[0] clears it; with evt_ready = 1, a single accept follows.
- Round-robin:
  - Setup: ch0, ch1, ch3 all periodic with period = 1; evt_ready = 1.
  - Required: grant order 0, 1, 3, 0, 1, 3, with an idle cycle between grants.
- Restart and stop:
  - Restart: ch1 periodic with period = 4; after 2 ticks, rewrite period = 4. Required: the next event occurs 4 ticks after the rewrite.
  - Stop: write cfg_enable = 0 in the same cycle as the expiring tick. Required: no event, busy[1] = 0.
- Invalid writes: write with period = 0, and write to cfg_ch = NUM_CH. Required: no state change on any channel; busy unchanged.

Source files
------------

// File: rtl/tick_event_scheduler.sv
// tick_event_scheduler: multi-channel tick-driven timer scheduler.
// Each channel counts ticks and raises an event once or periodically.
// Pending events are delivered one at a time, chosen round-robin, on a
// registered valid/ready port.
// Optional feature macro: TICK_SCHED_OVERRUN_EN adds sticky per-channel
// overrun flags (overrun output, ovr_clr input).
module tick_event_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      tick_in,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_WIDTH-1:0]      cfg_period,
    input  logic                      cfg_mode,
    input  logic                      cfg_enable,
    output logic                      evt_valid,
    output logic [$clog2(NUM_CH)-1:0] evt_ch,
    input  logic                      evt_ready,
    output logic [NUM_CH-1:0]         busy
`ifdef TICK_SCHED_OVERRUN_EN
    ,
    output logic [NUM_CH-1:0]         overrun,
    input  logic [NUM_CH-1:0]         ovr_clr
`endif
);

    localparam int                   CH_W       = $clog2(NUM_CH);
    localparam logic [CH_W:0]        NUM_CH_EXT = (CH_W + 1)'(NUM_CH);
    localparam logic [CH_W-1:0]      LAST_CH    = CH_W'(NUM_CH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } chState_e;

    chState_e             r_state      [NUM_CH];
    chState_e             w_stateNext  [NUM_CH];
    logic [CNT_WIDTH-1:0] r_cnt        [NUM_CH];
    logic [CNT_WIDTH-1:0] w_cntNext    [NUM_CH];
    logic [CNT_WIDTH-1:0] r_period     [NUM_CH];
    logic [CNT_WIDTH-1:0] w_periodNext [NUM_CH];
    logic [NUM_CH-1:0]    r_mode;
    logic [NUM_CH-1:0]    w_modeNext;

    logic [NUM_CH-1:0]    w_wrSel;
    logic [NUM_CH-1:0]    w_expire;
    logic [NUM_CH-1:0]    r_pend;
    logic [NUM_CH-1:0]    w_pendNext;
    logic [NUM_CH-1:0]    w_clr;
    logic [NUM_CH-1:0]    w_pendRot;

    logic                 w_cfgValid;
    logic                 w_accept;
    logic                 w_grantFound;
    logic [CH_W:0]        w_grantSum;
    logic [CH_W-1:0]      w_grantCh;

    logic                 r_evtValid;
    logic [CH_W-1:0]      r_evtCh;
    logic [CH_W-1:0]      r_ptr;

    // Writes to channel numbers beyond NUM_CH are dropped entirely.
    assign w_cfgValid = ({1'b0, cfg_ch} < NUM_CH_EXT);
    assign w_accept   = r_evtValid && evt_ready;

    // Decode which channel the configuration write and the accepted event address.
    always_comb begin
        w_wrSel = '0;
        w_clr   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wrSel[i] = cfg_we && w_cfgValid && (cfg_ch == CH_W'(i));
            w_clr[i]   = w_accept && (r_evtCh == CH_W'(i));
        end
    end

    // Per-channel next state: an effective write beats the tick; otherwise count down.
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_periodNext = r_period;
        w_modeNext   = r_mode;
        w_expire     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_wrSel[i] && cfg_enable && (cfg_period != '0)) begin
                w_stateNext[i]  = S_RUN;
                w_cntNext[i]    = cfg_period;
                w_periodNext[i] = cfg_period;
                w_modeNext[i]   = cfg_mode;
            end else if (w_wrSel[i] && !cfg_enable) begin
                w_stateNext[i] = S_IDLE;
            end else if ((r_state[i] == S_RUN) && tick_in) begin
                if (r_cnt[i] > CNT_ONE) begin
                    w_cntNext[i] = r_cnt[i] - CNT_ONE;
                end else begin
                    w_expire[i] = 1'b1;
                    if (r_mode[i]) begin
                        w_cntNext[i] = r_period[i];
                    end else begin
                        w_stateNext[i] = S_IDLE;
                    end
                end
            end
        end
    end

    // Channel state, counter and configuration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i]  <= S_IDLE;
                r_cnt[i]    <= '0;
                r_period[i] <= '0;
            end
            r_mode <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_cnt    <= w_cntNext;
            r_period <= w_periodNext;
            r_mode   <= w_modeNext;
        end
    end

    // A new expiry keeps pend set even when the same channel is being accepted.
    assign w_pendNext = w_expire | (r_pend & ~w_clr);

    // Round-robin pick: rotate pend so the pointer sits at bit 0, take the lowest set bit.
    always_comb begin
        w_pendRot    = NUM_CH'({r_pend, r_pend} >> r_ptr);
        w_grantFound = 1'b0;
        w_grantSum   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_pendRot[k]) begin
                w_grantFound = 1'b1;
                w_grantSum   = {1'b0, r_ptr} + (CH_W + 1)'(k);
            end
        end
        if (w_grantSum >= NUM_CH_EXT) begin
            w_grantSum = w_grantSum - NUM_CH_EXT;
        end
        w_grantCh = w_grantSum[CH_W-1:0];
    end

    // Pending flags and the locked event; an accept forces one idle cycle before the next grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend     <= '0;
            r_evtValid <= 1'b0;
            r_evtCh    <= '0;
            r_ptr      <= '0;
        end else begin
            r_pend <= w_pendNext;
            if (w_accept) begin
                r_evtValid <= 1'b0;
                r_ptr      <= (r_evtCh == LAST_CH) ? '0 : (r_evtCh + CH_W'(1));
            end else if (!r_evtValid && w_grantFound) begin
                r_evtValid <= 1'b1;
                r_evtCh    <= w_grantCh;
            end
        end
    end

`ifdef TICK_SCHED_OVERRUN_EN
    logic [NUM_CH-1:0] r_overrun;
    logic [NUM_CH-1:0] w_ovrSet;

    assign w_ovrSet = w_expire & r_pend & ~w_clr;

    // Sticky overrun flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= '0;
        end else begin
            r_overrun <= w_ovrSet | (r_overrun & ~ovr_clr);
        end
    end

    assign overrun = r_overrun;
`endif

    // Busy mirrors the RUN state of each channel.
    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            busy[i] = (r_state[i] == S_RUN);
        end
    end

    assign evt_valid = r_evtValid;
    assign evt_ch    = r_evtCh;

endmodule

// File: tb/tb_tick_event_scheduler.sv
// tb_tick_event_scheduler: directed bench for tick_event_scheduler with a
// behavioural model checked every cycle and hand-computed expectations.
module tb_tick_event_scheduler;

    localparam int NCH = 4;

    logic        clk;
    logic        resetN;
    logic        tickIn;
    logic        cfgWe;
    logic [1:0]  cfgCh;
    logic [15:0] cfgPeriod;
    logic        cfgMode;
    logic        cfgEnable;
    logic        evtReady;
    logic        evtValid;
    logic [1:0]  evtCh;
    logic [3:0]  busy;
    logic [3:0]  ovrClr;
`ifdef TICK_SCHED_OVERRUN_EN
    logic [3:0]  overrun;
    logic [2:0]  overrun2;
`endif
    logic        cfgWe2;
    logic [1:0]  cfgCh2;
    logic        evtValid2;
    logic [1:0]  evtCh2;
    logic [2:0]  busy2;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit           mRun      [NCH];
    int           mSeen     [NCH];
    int           mPeriod   [NCH];
    bit           mPeriodic [NCH];
    bit [NCH-1:0] mPend;
    bit [NCH-1:0] mOvr;
    bit           mValid;
    int           mCh;
    int           mPtr;
    int           cyc;
    int           acceptLog[$];
    int           acceptCyc[$];

    tick_event_scheduler #(.NUM_CH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(resetN), .tick_in(tickIn), .cfg_we(cfgWe), .cfg_ch(cfgCh),
        .cfg_period(cfgPeriod), .cfg_mode(cfgMode), .cfg_enable(cfgEnable),
        .evt_valid(evtValid), .evt_ch(evtCh), .evt_ready(evtReady), .busy(busy)
`ifdef TICK_SCHED_OVERRUN_EN
        , .overrun(overrun), .ovr_clr(ovrClr)
`endif
    );

    tick_event_scheduler #(.NUM_CH(3), .CNT_WIDTH(16)) dut3 (
        .clk(clk), .reset_n(resetN), .tick_in(tickIn), .cfg_we(cfgWe2), .cfg_ch(cfgCh2),
        .cfg_period(cfgPeriod), .cfg_mode(cfgMode), .cfg_enable(cfgEnable),
        .evt_valid(evtValid2), .evt_ch(evtCh2), .evt_ready(evtReady), .busy(busy2)
`ifdef TICK_SCHED_OVERRUN_EN
        , .overrun(overrun2), .ovr_clr(3'b000)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] ch, input logic [15:0] period,
                                 input logic mode, input logic en, input logic tick);
        cfgWe     = we;
        cfgCh     = ch;
        cfgPeriod = period;
        cfgMode   = mode;
        cfgEnable = en;
        tickIn    = tick;
        @(negedge clk);
        cfgWe  = 1'b0;
        tickIn = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] modelBusy();
        logic [3:0] b;
        for (int i = 0; i < NCH; i++) b[i] = mRun[i];
        return b;
    endfunction

    // Model: tick counting up to the period, pend/overrun rules, round-robin delivery
    always @(posedge clk or negedge resetN) begin : modelProc
        bit [NCH-1:0] expNow;
        bit           accept;
        bit           found;
        int           pick;
        if (!resetN) begin
            for (int i = 0; i < NCH; i++) begin
                mRun[i]      <= 1'b0;
                mSeen[i]     <= 0;
                mPeriod[i]   <= 0;
                mPeriodic[i] <= 1'b0;
            end
            mPend  <= '0;
            mOvr   <= '0;
            mValid <= 1'b0;
            mCh    <= 0;
            mPtr   <= 0;
        end else begin
            accept = mValid && evtReady;
            expNow = '0;
            for (int i = 0; i < NCH; i++) begin
                if (cfgWe && cfgCh == i && cfgEnable && cfgPeriod != 0) begin
                    mRun[i]      <= 1'b1;
                    mSeen[i]     <= 0;
                    mPeriod[i]   <= int'(cfgPeriod);
                    mPeriodic[i] <= cfgMode;
                end else if (cfgWe && cfgCh == i && !cfgEnable) begin
                    mRun[i] <= 1'b0;
                end else if (mRun[i] && tickIn) begin
                    if (mSeen[i] + 1 == mPeriod[i]) begin
                        expNow[i] = 1'b1;
                        mSeen[i] <= 0;
                        if (!mPeriodic[i]) mRun[i] <= 1'b0;
                    end else begin
                        mSeen[i] <= mSeen[i] + 1;
                    end
                end
            end
            for (int i = 0; i < NCH; i++) begin
                mPend[i] <= expNow[i] | (mPend[i] & !(accept && mCh == i));
                if (expNow[i] && mPend[i] && !(accept && mCh == i)) mOvr[i] <= 1'b1;
                else if (ovrClr[i]) mOvr[i] <= 1'b0;
            end
            found = 1'b0;
            pick  = 0;
            for (int k = 0; k < NCH; k++) begin
                if (!found && mPend[(mPtr + k) % NCH]) begin
                    found = 1'b1;
                    pick  = (mPtr + k) % NCH;
                end
            end
            if (accept) begin
                acceptLog.push_back(mCh);
                acceptCyc.push_back(cyc);
                mValid <= 1'b0;
                mPtr   <= (mCh + 1) % NCH;
            end else if (!mValid && found) begin
                mValid <= 1'b1;
                mCh    <= pick;
            end
            cyc <= cyc + 1;
        end
    end

    // Every cycle out of reset, the DUT must agree with the model
    always @(negedge clk) begin
        if (resetN) begin
            checkOutput("cmp_busy", busy, modelBusy());
            checkOutput("cmp_evt_valid", evtValid, mValid);
            if (mValid) checkOutput("cmp_evt_ch", evtCh, mCh);
`ifdef TICK_SCHED_OVERRUN_EN
            checkOutput("cmp_overrun", overrun, mOvr);
`endif
        end
    end

    initial begin
        cyc = 0;
        resetN = 1'b0; tickIn = 1'b0; cfgWe = 1'b0; cfgCh = '0; cfgPeriod = '0;
        cfgMode = 1'b0; cfgEnable = 1'b0; evtReady = 1'b0; ovrClr = '0;
        cfgWe2 = 1'b0; cfgCh2 = '0;
        idleCycles(2);
        checkOutput("reset_evt_valid", evtValid, 0);
        checkOutput("reset_evt_ch", evtCh, 0);
        checkOutput("reset_busy", busy, 0);
        resetN = 1'b1;
        idleCycles(1);

        // One-shot channel 2, period 3, tick every 5 cycles
        $display("[TB] one-shot channel 2");
        acceptLog.delete(); acceptCyc.delete();
        evtReady = 1'b1;
        applyStimulus(1, 2, 3, 0, 1, 0);
        checkOutput("A_busy_after_write", busy[2], 1);
        for (int t = 1; t <= 3; t++) begin
            applyStimulus(0, 0, 0, 0, 0, 1);
            if (t < 3) idleCycles(4);
        end
        checkOutput("A_busy_falls", busy[2], 0);
        checkOutput("A_valid_not_yet", evtValid, 0);
        idleCycles(1);
        checkOutput("A_valid", evtValid, 1);
        checkOutput("A_ch", evtCh, 2);
        idleCycles(6);
        checkOutput("A_event_count", acceptLog.size(), 1);
        if (acceptLog.size() > 0) checkOutput("A_event_ch", acceptLog[0], 2);

        // Periodic channel 0, period 2, held off by back-pressure
        $display("[TB] periodic channel 0 with back-pressure");
        acceptLog.delete(); acceptCyc.delete();
        evtReady = 1'b0;
        applyStimulus(1, 0, 2, 1, 1, 0);
        for (int t = 1; t <= 6; t++) begin
            applyStimulus(0, 0, 0, 0, 0, 1);
`ifdef TICK_SCHED_OVERRUN_EN
            if (t == 3) checkOutput("B_overrun_before", overrun[0], 0);
            if (t == 4) checkOutput("B_overrun_after4", overrun[0], 1);
`endif
            idleCycles(1);
            if (t == 2) begin
                checkOutput("B_valid", evtValid, 1);
                checkOutput("B_ch", evtCh, 0);
            end
        end
        checkOutput("B_valid_held", evtValid, 1);
        checkOutput("B_ch_held", evtCh, 0);
`ifdef TICK_SCHED_OVERRUN_EN
        ovrClr = 4'b0001;
        idleCycles(1);
        ovrClr = 4'b0000;
        checkOutput("B_overrun_cleared", overrun[0], 0);
`endif
        evtReady = 1'b1;
        idleCycles(5);
        checkOutput("B_accept_count", acceptLog.size(), 1);
        checkOutput("B_valid_after", evtValid, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("B_busy_stopped", busy, 0);

        // Asynchronous reset in the middle of activity
        $display("[TB] reset mid-operation");
        acceptLog.delete(); acceptCyc.delete();
        evtReady = 1'b0;
        applyStimulus(1, 1, 5, 1, 1, 0);
        applyStimulus(1, 0, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("R_setup_valid", evtValid, 1);
        checkOutput("R_setup_busy", busy, 4'b0010);
        #2 resetN = 1'b0;
        #1;
        checkOutput("R_async_valid", evtValid, 0);
        checkOutput("R_async_ch", evtCh, 0);
        checkOutput("R_async_busy", busy, 0);
        @(negedge clk);
        resetN = 1'b1;
        evtReady = 1'b1;
        repeat (4) begin
            applyStimulus(0, 0, 0, 0, 0, 1);
            idleCycles(1);
        end
        checkOutput("R_no_event", acceptLog.size(), 0);
        checkOutput("R_busy_idle", busy, 0);

        // Round-robin between channels 0, 1 and 3
        $display("[TB] round-robin");
        acceptLog.delete(); acceptCyc.delete();
        evtReady = 1'b1;
        applyStimulus(1, 0, 1, 1, 1, 0);
        applyStimulus(1, 1, 1, 1, 1, 0);
        applyStimulus(1, 3, 1, 1, 1, 0);
        repeat (12) applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 3, 0, 0, 0, 0);
        idleCycles(12);
        checkOutput("C_count_at_least6", acceptLog.size() >= 6, 1);
        if (acceptLog.size() >= 6) begin
            int expOrder[6];
            expOrder = '{0, 1, 3, 0, 1, 3};
            for (int k = 0; k < 6; k++) checkOutput($sformatf("C_order%0d", k), acceptLog[k], expOrder[k]);
            for (int k = 0; k < 5; k++) checkOutput($sformatf("C_gap%0d", k), acceptCyc[k+1] - acceptCyc[k], 2);
        end
        checkOutput("C_drained", evtValid, 0);

        // Restart with the same period, then stop on the expiring tick
        $display("[TB] restart and stop");
        acceptLog.delete(); acceptCyc.delete();
        applyStimulus(1, 1, 4, 1, 1, 0);
        repeat (2) begin applyStimulus(0, 0, 0, 0, 0, 1); idleCycles(1); end
        applyStimulus(1, 1, 4, 1, 1, 0);
        repeat (3) begin applyStimulus(0, 0, 0, 0, 0, 1); idleCycles(1); end
        checkOutput("D_no_early_event", acceptLog.size(), 0);
        checkOutput("D_no_early_valid", evtValid, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        idleCycles(1);
        checkOutput("D_valid_4th", evtValid, 1);
        checkOutput("D_ch_4th", evtCh, 1);
        idleCycles(2);
        checkOutput("D_one_event", acceptLog.size(), 1);
        repeat (3) begin applyStimulus(0, 0, 0, 0, 0, 1); idleCycles(1); end
        applyStimulus(1, 1, 0, 0, 0, 1);
        checkOutput("D_stop_busy", busy[1], 0);
        idleCycles(3);
        repeat (2) begin applyStimulus(0, 0, 0, 0, 0, 1); idleCycles(1); end
        checkOutput("D_stop_no_event", acceptLog.size(), 1);
        checkOutput("D_stop_valid", evtValid, 0);

        // Invalid writes: zero period, and a channel number beyond the count
        $display("[TB] invalid writes");
        acceptLog.delete(); acceptCyc.delete();
        applyStimulus(1, 2, 5, 1, 1, 0);
        checkOutput("E_busy_base", busy, 4'b0100);
        applyStimulus(1, 0, 0, 1, 1, 0);
        checkOutput("E_zero_period_ch0", busy, 4'b0100);
        applyStimulus(1, 2, 0, 0, 1, 0);
        checkOutput("E_zero_period_ch2", busy, 4'b0100);
        repeat (5) applyStimulus(0, 0, 0, 0, 0, 1);
        idleCycles(2);
        checkOutput("E_ch2_still_periodic", acceptLog.size(), 1);
        checkOutput("E_ch2_still_busy", busy[2], 1);
        applyStimulus(1, 2, 0, 0, 0, 0);

        cfgCh2 = 2'd3; cfgPeriod = 16'd1; cfgMode = 1'b1; cfgEnable = 1'b1; cfgWe2 = 1'b1;
        @(negedge clk);
        cfgWe2 = 1'b0;
        checkOutput("E_bad_ch_busy", busy2, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        idleCycles(2);
        checkOutput("E_bad_ch_no_event", evtValid2, 0);
        cfgCh2 = 2'd2; cfgPeriod = 16'd1; cfgMode = 1'b1; cfgEnable = 1'b1; cfgWe2 = 1'b1;
        @(negedge clk);
        cfgWe2 = 1'b0;
        checkOutput("E_good_ch_busy", busy2, 3'b100);
        applyStimulus(0, 0, 0, 0, 0, 1);
        idleCycles(1);
        checkOutput("E_good_ch_valid", evtValid2, 1);
        checkOutput("E_good_ch_ch", evtCh2, 2);
        idleCycles(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
